uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (txdata/txbegin/txbusy handshake) between two byte sources.
  - Requester 0: CPU register-write path (UARTDATA writes).
  - Requester 1: internal sequencer, e.g. a boot/debug message streamer.
- Latches one byte per grant, drives txbegin until the UART acknowledges with txbusy, then holds the grant until txbusy falls.
- Fair round-robin between the two requesters.

---
 rtl/uart_arb_pkg.sv | 11 +
 rtl/uart_rr_pick.sv | 19 +
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and requester ids.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_SEQ = 1'b1;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to whichever requester was not granted last.
module uart_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any,
  output logic       winner
);

  always_comb begin
    any = |valid;
    if (&valid) begin
      winner = ~last_grant;
    end else begin
      winner = valid[1];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the CPU write path and the internal sequencer.
// Define UART_TX_TIMEOUT_EN to abort a START that the UART never acknowledges.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] txdata,
  output logic       txbegin,
  input  logic       txbusy,
  output logic       busy,
  output logic       grant_id,
  output logic       err_timeout
);

  // Handshake: a requester holds valid/data until its one-cycle ready pulse; ready
  // means the byte was latched at that edge. txbegin holds until txbusy is seen high.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("uart_tx_arbiter: CNT_W cannot hold TIMEOUT_CYCLES");
  end

  logic [1:0] state_q, state_d;
  logic [7:0] txdata_q, txdata_d;
  logic [1:0] ready_q, ready_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       pick_any, pick_winner;
  logic       err_q, err_d;

  uart_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

`ifdef UART_TX_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_expired;

  assign start_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic start_expired;

  assign start_expired = 1'b0;
  assign err_q         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      txdata_q     <= 8'h00;
      ready_q      <= 2'b00;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_SEQ;
    end else begin
      state_q      <= state_d;
      txdata_q     <= txdata_d;
      ready_q      <= ready_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    txdata_d     = txdata_q;
    ready_d      = 2'b00;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
`ifdef UART_TX_TIMEOUT_EN
    // Counts cycles spent in START; zero on the cycle START is entered.
    cnt_d = (state_q == ST_START) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        // A txbusy left over from someone else's transfer blocks new grants.
        if (pick_any && !txbusy) begin
          state_d      = ST_START;
          txdata_d     = pick_winner ? req1_data : req0_data;
          ready_d      = pick_winner ? 2'b10 : 2'b01;
          grant_d      = pick_winner;
          last_grant_d = pick_winner;
        end
      end
      ST_START: begin
        if (txbusy) begin
          state_d = ST_WAIT;
        end else if (start_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!txbusy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    txdata      = txdata_q;
    txbegin     = (state_q == ST_START);
    busy        = (state_q != ST_IDLE);
    grant_id    = grant_q;
    req0_ready  = ready_q[0];
    req1_ready  = ready_q[1];
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios, then randomized
// traffic against a transaction-level round-robin model with a byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int TO_CYC    = 16;
  localparam int N_PER_REQ = 25;
  localparam int MAX_CYC   = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] txdata;
  logic       txbegin, txbusy, busy, grant_id, err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] src_q0[$];
  logic [7:0] src_q1[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .TIMEOUT_CYCLES (TO_CYC),
    .CNT_W          (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .txdata      (txdata),
    .txbegin     (txbegin),
    .txbusy      (txbusy),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays the UART for one transfer that was just granted (arbiter in START).
  task automatic serve(input int pre, input int len, input string tag);
    repeat (pre) begin
      check({tag, "_begin_hold"}, 32'(txbegin), 32'(1'b1));
      tick();
    end
    txbusy = 1'b1;
    tick();
    check({tag, "_begin_drop"}, 32'(txbegin), 32'(1'b0));
    check({tag, "_busy_wait"}, 32'(busy), 32'(1'b1));
    repeat (len - 1) tick();
    check({tag, "_busy_hold"}, 32'(busy), 32'(1'b1));
    txbusy = 1'b0;
    tick();
    check({tag, "_idle"}, 32'(busy), 32'(1'b0));
  endtask

  initial begin
    logic [7:0] nxt0, nxt1;
    logic       exp_w, model_last, outstanding;
    int         u_state, u_cnt, cyc, grants, cnt;
    logic       done;

    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; txbusy = 1'b0;
    tick();
    tick();
    check("rst_txbegin", 32'(txbegin), 0);
    check("rst_txdata", 32'(txdata), 0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_err", 32'(err_timeout), 0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 0.
    req0_valid = 1'b1; req0_data = 8'hA5;
    tick();
    check("single_ready", 32'({req1_ready, req0_ready}), 32'(2'b01));
    check("single_txdata", 32'(txdata), 32'h A5);
    check("single_txbegin", 32'(txbegin), 32'(1'b1));
    check("single_grant", 32'(grant_id), 0);
    req0_valid = 1'b0;
    tick();
    check("single_pulse", 32'(req0_ready), 0);
    serve(1, 10, "single");

    // Contention straight after the first tie-free grant history: 0 then 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    tick();
    check("cont_first", 32'({req1_ready, req0_ready}), 32'(2'b01));
    check("cont_first_data", 32'(txdata), 32'h11);
    req0_valid = 1'b0;
    serve(0, 3, "cont_a");
    tick();
    check("cont_second", 32'({req1_ready, req0_ready}), 32'(2'b10));
    check("cont_second_data", 32'(txdata), 32'h22);
    check("cont_second_grant", 32'(grant_id), 32'(1'b1));

    // Saturation: both stay valid, grants must alternate 0,1,0,1.
    nxt0 = 8'h33; nxt1 = 8'h44;
    req0_valid = 1'b1; req0_data = nxt0; req1_data = nxt1;
    serve(0, 2, "sat_pre");
    for (int i = 0; i < 4; i++) begin
      exp_w = (i % 2 == 1);
      tick();
      check("sat_ready", 32'({req1_ready, req0_ready}), exp_w ? 32'(2'b10) : 32'(2'b01));
      check("sat_grant", 32'(grant_id), 32'(exp_w));
      check("sat_data", 32'(txdata), exp_w ? 32'(nxt1) : 32'(nxt0));
      if (exp_w) begin nxt1 = nxt1 + 8'h22; req1_data = nxt1; end
      else begin nxt0 = nxt0 + 8'h22; req0_data = nxt0; end
      serve(0, 2, "sat");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Foreign busy: nothing granted until txbusy falls.
    txbusy = 1'b1; req1_valid = 1'b1; req1_data = 8'h5C;
    repeat (3) begin
      tick();
      check("fb_no_ready", 32'(req1_ready), 0);
      check("fb_no_begin", 32'(txbegin), 0);
      check("fb_idle", 32'(busy), 0);
    end
    txbusy = 1'b0;
    tick();
    check("fb_grant", 32'(req1_ready), 32'(1'b1));
    check("fb_data", 32'(txdata), 32'h5C);
    req1_valid = 1'b0;
    tick();
    check("fb_pulse", 32'(req1_ready), 0);

    // Withdrawal: a one-cycle request during WAIT leaves no trace.
    txbusy = 1'b1;
    tick();
    req0_valid = 1'b1; req0_data = 8'h99;
    tick();
    check("wd_ready_wait", 32'(req0_ready), 0);
    req0_valid = 1'b0; txbusy = 1'b0;
    tick();
    repeat (3) begin
      tick();
      check("wd_no_begin", 32'(txbegin), 0);
      check("wd_no_ready", 32'(req0_ready), 0);
      check("wd_idle", 32'(busy), 0);
    end

    // Reset in the middle of START.
    req1_valid = 1'b1; req1_data = 8'h3C;
    tick();
    check("mrst_begin", 32'(txbegin), 32'(1'b1));
    check("mrst_grant1", 32'(grant_id), 32'(1'b1));
    req1_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("mrst_txbegin", 32'(txbegin), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_grant", 32'(grant_id), 0);
    check("mrst_txdata", 32'(txdata), 0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_data = 8'hBB;
    tick();
    check("mrst_tie", 32'({req1_ready, req0_ready}), 32'(2'b01));
    check("mrst_tie_data", 32'(txdata), 32'hAA);
    req0_valid = 1'b0; req1_valid = 1'b0;
    serve(0, 3, "mrst");

`ifdef UART_TX_TIMEOUT_EN
    req0_valid = 1'b1; req0_data = 8'hE1;
    tick();
    req0_valid = 1'b0;
    cnt = 0;
    while (txbegin && cnt < 100) begin
      cnt++;
      tick();
    end
    check("to_cycles", 32'(cnt), 32'(TO_CYC));
    check("to_err", 32'(err_timeout), 32'(1'b1));
    check("to_idle", 32'(busy), 0);
    check("to_no_ready", 32'(req0_ready), 0);
    req1_valid = 1'b1; req1_data = 8'hE2;
    tick();
    check("to_new_ready", 32'(req1_ready), 32'(1'b1));
    check("to_new_begin", 32'(txbegin), 32'(1'b1));
    req1_valid = 1'b0;
    serve(0, 2, "to_after");
    check("to_sticky", 32'(err_timeout), 32'(1'b1));
`else
    check("no_timeout_err", 32'(err_timeout), 0);
`endif

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N_PER_REQ; i++) begin
      src_q0.push_back(8'($urandom_range(0, 255)));
      src_q1.push_back(8'($urandom_range(0, 255)));
    end
    model_last = 1'b1; outstanding = 1'b0;
    u_state = 0; u_cnt = 0; cyc = 0; grants = 0; done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      tick();
      cyc++;
      if (req0_ready || req1_ready) begin
        check("rnd_onehot", 32'(req0_ready & req1_ready), 0);
        check("rnd_overlap", 32'(outstanding), 0);
        exp_w = (req0_valid && req1_valid) ? !model_last : req1_valid;
        check("rnd_winner", 32'(req1_ready), 32'(exp_w));
        check("rnd_grant_id", 32'(grant_id), 32'(exp_w));
        model_last = exp_w;
        outstanding = 1'b1;
        grants++;
        if (exp_w && src_q1.size() > 0) begin
          exp_q.push_back(src_q1.pop_front());
          req1_valid = 1'b0;
        end else if (!exp_w && src_q0.size() > 0) begin
          exp_q.push_back(src_q0.pop_front());
          req0_valid = 1'b0;
        end
      end
      if (u_state == 2) begin
        if (u_cnt == 0) begin
          txbusy = 1'b0; u_state = 0; outstanding = 1'b0;
        end else begin
          u_cnt--;
        end
      end else begin
        if (u_state == 0 && txbegin) begin
          u_state = 1; u_cnt = int'($urandom_range(0, 3));
        end
        if (u_state == 1) begin
          if (u_cnt == 0) begin
            if (exp_q.size() > 0) check("rnd_txdata", 32'(txdata), 32'(exp_q.pop_front()));
            else check("rnd_spurious_begin", 32'(exp_q.size()), 1);
            txbusy = 1'b1; u_state = 2; u_cnt = int'($urandom_range(1, 5));
          end else begin
            u_cnt--;
          end
        end
      end
      if (!req0_valid) begin
        req0_data = 8'($urandom_range(0, 255));
        if (src_q0.size() > 0 && $urandom_range(0, 3) == 0) begin
          req0_valid = 1'b1; req0_data = src_q0[0];
        end
      end
      if (!req1_valid) begin
        req1_data = 8'($urandom_range(0, 255));
        if (src_q1.size() > 0 && $urandom_range(0, 3) == 0) begin
          req1_valid = 1'b1; req1_data = src_q1[0];
        end
      end
      done = (src_q0.size() == 0) && (src_q1.size() == 0) && !req0_valid && !req1_valid &&
             (exp_q.size() == 0) && (u_state == 0) && !busy;
    end
    check("rnd_drained", 32'(cyc < MAX_CYC), 32'(1'b1));
    check("rnd_grants", 32'(grants), 32'(2 * N_PER_REQ));
    check("rnd_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
